// File: rtl/traffic_ctrl_n.sv
// N-street traffic-light sequencer, optional walk phase under TRAFFIC_PED_EN; Moore outputs, lamps change the cycle after a qualified tick.
// No backpressure: hold freezes timer and state, and a tick seen while hold is high is discarded.
module traffic_ctrl_n #(
  parameter int N_STREET = 4,
  parameter int G_TIME   = 20,
  parameter int Y_TIME   = 3,
  parameter int R_TIME   = 2,
  parameter int W_TIME   = 10,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          hold,
  input  logic [N_STREET-1:0]           car_present,
  input  logic                          ped_req,
  output logic [3*N_STREET-1:0]         lights,
  output logic [$clog2(N_STREET)-1:0]   active,
  output logic                          fsm_g,
  output logic                          fsm_y,
  output logic                          fsm_r,
  output logic                          ped_walk
);

  localparam int AW = $clog2(N_STREET);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, dur_m1;
  logic [AW-1:0]    active_nxt, nxt_idx;
  logic             step, expire, go_walk;

`ifdef TRAFFIC_PED_EN
  logic ped_pend, ped_pend_nxt;
  assign go_walk = ped_pend | ped_req;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign go_walk    = 1'b0;
`endif

  always_comb begin
    dur_m1 = CNT_W'(R_TIME - 1);
    case (state)
      S_GREEN:  dur_m1 = CNT_W'(G_TIME - 1);
      S_YELLOW: dur_m1 = CNT_W'(Y_TIME - 1);
      S_ALLRED: dur_m1 = CNT_W'(R_TIME - 1);
      S_WALK:   dur_m1 = CNT_W'(W_TIME - 1);
      default:  dur_m1 = CNT_W'(R_TIME - 1);
    endcase
  end

  assign step   = tick & ~hold;
  assign expire = step & (cnt == dur_m1);

  // Scan from farthest to nearest so the nearest requester after active wins;
  // i == N_STREET lands on active itself, so it only survives as sole requester.
  always_comb begin
    int j;
    j       = 0;
    nxt_idx = (active == AW'(N_STREET - 1)) ? '0 : active + AW'(1);
    for (int i = N_STREET; i >= 1; i--) begin
      j = int'(active) + i;
      if (j >= N_STREET) j = j - N_STREET;
      if (car_present[AW'(j)]) nxt_idx = AW'(j);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    active_nxt = active;
    if (step) begin
      if (expire) begin
        cnt_nxt = '0;
        case (state)
          S_GREEN:  state_nxt = S_YELLOW;
          S_YELLOW: state_nxt = S_ALLRED;
          S_ALLRED: begin
            if (go_walk) begin
              state_nxt = S_WALK;
            end else begin
              state_nxt  = S_GREEN;
              active_nxt = nxt_idx;
            end
          end
          S_WALK: begin
            state_nxt  = S_GREEN;
            active_nxt = nxt_idx;
          end
          default:  state_nxt = S_ALLRED;
        endcase
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

`ifdef TRAFFIC_PED_EN
  // A request on the walk-entry cycle is consumed by that same walk.
  always_comb begin
    ped_pend_nxt = ped_pend;
    if (ped_req && state != S_WALK) ped_pend_nxt = 1'b1;
    if (state_nxt == S_WALK && state != S_WALK) ped_pend_nxt = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_ALLRED;
      cnt    <= '0;
      active <= AW'(N_STREET - 1);
`ifdef TRAFFIC_PED_EN
      ped_pend <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      active <= active_nxt;
`ifdef TRAFFIC_PED_EN
      ped_pend <= ped_pend_nxt;
`endif
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < N_STREET; i++) begin
      lights[3*i +: 3] = 3'b001;
      if (i == int'(active)) begin
        if (state == S_GREEN)  lights[3*i +: 3] = 3'b100;
        if (state == S_YELLOW) lights[3*i +: 3] = 3'b010;
      end
    end
  end

  assign fsm_g = (state == S_GREEN);
  assign fsm_y = (state == S_YELLOW);
  assign fsm_r = (state == S_ALLRED) || (state == S_WALK);

`ifdef TRAFFIC_PED_EN
  assign ped_walk = (state == S_WALK);
`else
  assign ped_walk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench for traffic_ctrl_n: per-cycle expected lamps/flags queued from the phase plan.
module tb_traffic_ctrl_n;

  logic       clk = 1'b0;
  logic       rst, tick, hold, ped_req;
  logic [2:0] car_present;
  logic [8:0] lights;
  logic [1:0] active;
  logic       fsm_g, fsm_y, fsm_r, ped_walk;

  int passed = 0;
  int total  = 0;
  logic [14:0] sb[$];
  logic [14:0] obs_v;

  traffic_ctrl_n #(
    .N_STREET(3), .G_TIME(4), .Y_TIME(2), .R_TIME(1), .W_TIME(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .hold(hold),
    .car_present(car_present), .ped_req(ped_req),
    .lights(lights), .active(active),
    .fsm_g(fsm_g), .fsm_y(fsm_y), .fsm_r(fsm_r), .ped_walk(ped_walk)
  );

  always #5 clk = ~clk;

  assign obs_v = {lights, active, fsm_g, fsm_y, fsm_r, ped_walk};

  // phase: 0=GREEN 1=YELLOW 2=ALLRED 3=WALK
  function automatic logic [14:0] ev(int ph, int act);
    logic [8:0] l;
    for (int i = 0; i < 3; i++) begin
      if (i == act && ph == 0)      l[3*i +: 3] = 3'b100;
      else if (i == act && ph == 1) l[3*i +: 3] = 3'b010;
      else                          l[3*i +: 3] = 3'b001;
    end
    return {l, 2'(act), ph == 0, ph == 1, ph >= 2, ph == 3};
  endfunction

  task automatic push_n(int ph, int act, int n);
    for (int i = 0; i < n; i++) sb.push_back(ev(ph, act));
  endtask

  task automatic apply_reset(logic [2:0] car);
    rst = 1'b1; tick = 1'b1; hold = 1'b0; ped_req = 1'b0; car_present = car;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 1); push_n(0, 0, 4); push_n(1, 0, 2); push_n(2, 0, 1); push_n(0, 1, 1);
    apply_reset(3'b000);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL reset_seq cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
  endtask

  task automatic test_sole_requester();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 1);
    for (int r = 0; r < 2; r++) begin
      push_n(0, 2, 4); push_n(1, 2, 2); push_n(2, 2, 1);
    end
    push_n(0, 2, 1);
    apply_reset(3'b100);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL sole_req cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
  endtask

  task automatic test_skip();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 1);
    push_n(0, 0, 4); push_n(1, 0, 2); push_n(2, 0, 1);
    push_n(0, 1, 4); push_n(1, 1, 2); push_n(2, 1, 1);
    push_n(0, 0, 1);
    apply_reset(3'b011);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL skip cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
  endtask

  task automatic test_hold();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 1); push_n(0, 0, 9); push_n(1, 0, 2); push_n(2, 0, 1); push_n(0, 1, 1);
    apply_reset(3'b000);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL hold cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      hold = (k >= 2 && k <= 6);
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
    hold = 1'b0;
  endtask

  task automatic test_slow_tick();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 3); push_n(0, 0, 12); push_n(1, 0, 6); push_n(2, 0, 3); push_n(0, 1, 1);
    apply_reset(3'b000);
    tick = 1'b0;
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL slow_tick cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      tick = ((k + 1) % 3 == 0);
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
    tick = 1'b1;
  endtask

  task automatic test_ped();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 1); push_n(0, 0, 4); push_n(1, 0, 2); push_n(2, 0, 1);
`ifdef TRAFFIC_PED_EN
    push_n(3, 0, 3);
`endif
    push_n(0, 1, 4); push_n(1, 1, 2); push_n(2, 1, 1); push_n(0, 2, 1);
    apply_reset(3'b000);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL ped cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      ped_req = (k == 1 || k == 8);
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
    ped_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    int k;
    logic [14:0] e;
    sb.delete();
    push_n(2, 2, 1); push_n(0, 0, 4); push_n(1, 0, 2); push_n(2, 0, 1);
    push_n(0, 1, 4); push_n(1, 1, 1); push_n(2, 2, 1); push_n(0, 0, 1);
    apply_reset(3'b000);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_v !== e) $display("FAIL mid_reset cyc %0d: got %h want %h", k, obs_v, e);
      else passed++;
      rst = (k == 12);
      if (sb.size() > 0) begin @(posedge clk); #1; end
      k++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; hold = 1'b0; ped_req = 1'b0; car_present = '0;
    test_reset();
    test_sole_requester();
    test_skip();
    test_hold();
    test_slow_tick();
    test_ped();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
